numbers_collision_ctrl: RTL and testbench

//  Per-frame collision arbiter upstream of the multiple-numbers display. Watches player vs. number

---
 rtl/numbers_pkg.sv | 25 ++
 rtl/numbers_collision_ctrl_if.sv | 36 +++
 rtl/pulse_stretcher.sv | 40 ++++
 rtl/numbers_collision_ctrl.sv | 98 +++++++++
 tb/tb_numbers_collision_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/numbers_pkg.sv
// Shared definitions for the numbers collision controller: default sizes,
// the per-number mask type and small arithmetic helpers.
package numbers_pkg;

  localparam int NUMBERS_DEFAULT = 3;
  localparam int COUNT_W_DEFAULT = 4;

  typedef logic [NUMBERS_DEFAULT-1:0] num_mask_t;

  // Number of set bits in a number mask.
  function automatic int popcount(input num_mask_t m);
    int n;
    n = 0;
    for (int i = 0; i < NUMBERS_DEFAULT; i++) begin
      n += int'(m[i]);
    end
    return n;
  endfunction

  // Addition clamped at max_val, used by the hit counter.
  function automatic int sat_add(input int a, input int b, input int max_val);
    return ((a + b) > max_val) ? max_val : (a + b);
  endfunction

endpackage

// File: rtl/numbers_collision_ctrl_if.sv
// Bus between the frame/display side and the collision controller.
// The hitSound signal exists only when NUM_COLL_SOUND_EN is defined.
interface numbers_collision_ctrl_if #(
  parameter int NUMBERS = numbers_pkg::NUMBERS_DEFAULT,
  parameter int COUNT_W = numbers_pkg::COUNT_W_DEFAULT
);
  logic               startOfFrame;
  logic               levelRestart;
  logic               playerDR;
  logic [NUMBERS-1:0] numbersDR;
  logic [NUMBERS-1:0] singleHit;
  logic [NUMBERS-1:0] hitMask;
  logic [COUNT_W-1:0] hitCount;
  logic               allCleared;
`ifdef NUM_COLL_SOUND_EN
  logic               hitSound;
`endif

  // Frame source / display side: drives requests, consumes hit results.
  modport master (
    output startOfFrame, levelRestart, playerDR, numbersDR,
    input  singleHit, hitMask, hitCount, allCleared
`ifdef NUM_COLL_SOUND_EN
    , input hitSound
`endif
  );

  // Collision controller side.
  modport slave (
    input  startOfFrame, levelRestart, playerDR, numbersDR,
    output singleHit, hitMask, hitCount, allCleared
`ifdef NUM_COLL_SOUND_EN
    , output hitSound
`endif
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a CYCLES-long pulse; a trigger during
// the pulse restarts it, clr forces it low. Only built with NUM_COLL_SOUND_EN.
`ifdef NUM_COLL_SOUND_EN
module pulse_stretcher #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic trig,
  output logic pulse
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  // Reload on trigger, otherwise count down to zero; clear has priority.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (trig) begin
      cnt_next = CW'(CYCLES);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign pulse = (cnt_reg != '0);
endmodule
`endif

// File: rtl/numbers_collision_ctrl.sv
// Per-frame collision arbiter: collects player/number overlaps during a
// frame and, at the next start-of-frame, pulses singleHit for each newly hit
// number, updating the sticky hit mask and a saturating hit count.
// Optional feature macro: NUM_COLL_SOUND_EN adds the hitSound pulse output.
module numbers_collision_ctrl #(
  parameter int NUMBERS   = numbers_pkg::NUMBERS_DEFAULT,
  parameter int COUNT_W   = numbers_pkg::COUNT_W_DEFAULT
`ifdef NUM_COLL_SOUND_EN
  , parameter int SOUND_CYC = 16
`endif
) (
  input logic clk,
  input logic reset,
  numbers_collision_ctrl_if.slave bus
);
  import numbers_pkg::*;

  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic [NUMBERS-1:0] overlap;
  logic [NUMBERS-1:0] pending_reg, pending_next;
  logic [NUMBERS-1:0] single_hit_reg, single_hit_next;
  logic [NUMBERS-1:0] hit_mask_reg, hit_mask_next;
  logic [COUNT_W-1:0] hit_count_reg, hit_count_next;
  logic               all_cleared_reg, all_cleared_next;
  int                 pend_pop;

  // Overlap at this pixel, ignoring numbers that are already hidden.
  always_comb begin
    overlap = bus.playerDR ? (bus.numbersDR & ~hit_mask_reg) : '0;
  end

  // How many numbers are waiting to be committed.
  always_comb begin
    pend_pop = 0;
    for (int j = 0; j < NUMBERS; j++) begin
      pend_pop += int'(pending_reg[j]);
    end
  end

  // Collect every cycle; commit on startOfFrame; levelRestart wins over both.
  always_comb begin
    pending_next     = pending_reg | overlap;
    single_hit_next  = '0;
    hit_mask_next    = hit_mask_reg;
    hit_count_next   = hit_count_reg;
    all_cleared_next = &hit_mask_reg;
    if (bus.levelRestart) begin
      pending_next     = '0;
      hit_mask_next    = '0;
      hit_count_next   = '0;
      all_cleared_next = 1'b0;
    end else if (bus.startOfFrame) begin
      single_hit_next = pending_reg;
      hit_mask_next   = hit_mask_reg | pending_reg;
      hit_count_next  = COUNT_W'(sat_add(int'(hit_count_reg), pend_pop, CNT_MAX));
      // The overlap seen on the start-of-frame pixel opens the new frame;
      // numbers being committed right now must not be collected again.
      pending_next    = overlap & ~pending_reg;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reg     <= '0;
      single_hit_reg  <= '0;
      hit_mask_reg    <= '0;
      hit_count_reg   <= '0;
      all_cleared_reg <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      single_hit_reg  <= single_hit_next;
      hit_mask_reg    <= hit_mask_next;
      hit_count_reg   <= hit_count_next;
      all_cleared_reg <= all_cleared_next;
    end
  end

  assign bus.singleHit  = single_hit_reg;
  assign bus.hitMask    = hit_mask_reg;
  assign bus.hitCount   = hit_count_reg;
  assign bus.allCleared = all_cleared_reg;

`ifdef NUM_COLL_SOUND_EN
  // Sound starts in the same cycle singleHit rises, so trigger on its next value.
  pulse_stretcher #(
    .CYCLES (SOUND_CYC)
  ) u_sound (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.levelRestart),
    .trig  (|single_hit_next),
    .pulse (bus.hitSound)
  );
`endif

endmodule

// File: tb/tb_numbers_collision_ctrl.sv
// Bench for numbers_collision_ctrl: directed scenarios followed by random
// frames, checked against a frame-level reference model. Two instances are
// driven in parallel: COUNT_W=4 and COUNT_W=1 (to reach hit-count saturation).
module tb_numbers_collision_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sof, lr, pdr;
  logic [2:0] ndr;

  int tests = 0;
  int fails = 0;

  // Reference model: numbers seen this frame, hidden set, counts, outputs.
  logic [2:0] m_seen, m_mask, m_pulse;
  int         m_cnt_a, m_cnt_b;
  logic       m_all;
  int         m_snd;

  always #5 clk = ~clk;

  numbers_collision_ctrl_if #(.NUMBERS(3), .COUNT_W(4)) bus_a ();
  numbers_collision_ctrl_if #(.NUMBERS(3), .COUNT_W(1)) bus_b ();

  assign bus_a.startOfFrame = sof;
  assign bus_a.levelRestart = lr;
  assign bus_a.playerDR     = pdr;
  assign bus_a.numbersDR    = ndr;
  assign bus_b.startOfFrame = sof;
  assign bus_b.levelRestart = lr;
  assign bus_b.playerDR     = pdr;
  assign bus_b.numbersDR    = ndr;

  numbers_collision_ctrl #(.NUMBERS(3), .COUNT_W(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  numbers_collision_ctrl #(.NUMBERS(3), .COUNT_W(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_seen  = 3'b000;
    m_mask  = 3'b000;
    m_pulse = 3'b000;
    m_cnt_a = 0;
    m_cnt_b = 0;
    m_all   = 1'b0;
    m_snd   = 0;
  endtask

  // One clock edge of the model, from the frame-level rules.
  task automatic model_edge();
    logic [2:0] touched;
    int         newly;
    touched = pdr ? ndr : 3'b000;
    if (lr) begin
      model_reset();
    end else begin
      m_all = (m_mask == 3'b111);
      if (sof) begin
        m_pulse = m_seen;
        m_mask  = m_mask | m_seen;
        newly   = $countones(m_seen);
        m_cnt_a = (m_cnt_a + newly > 15) ? 15 : m_cnt_a + newly;
        m_cnt_b = (m_cnt_b + newly > 1) ? 1 : m_cnt_b + newly;
        m_seen  = touched & ~m_mask;
      end else begin
        m_pulse = 3'b000;
        m_seen  = m_seen | (touched & ~m_mask);
      end
      if (m_pulse != 3'b000) m_snd = 16;
      else if (m_snd > 0) m_snd = m_snd - 1;
    end
  endtask

  task automatic check_all();
    chk("singleHit_a", 32'(bus_a.singleHit), 32'(m_pulse));
    chk("hitMask_a", 32'(bus_a.hitMask), 32'(m_mask));
    chk("hitCount_a", 32'(bus_a.hitCount), 32'(m_cnt_a));
    chk("allCleared_a", 32'(bus_a.allCleared), 32'(m_all));
    chk("singleHit_b", 32'(bus_b.singleHit), 32'(m_pulse));
    chk("hitCount_b", 32'(bus_b.hitCount), 32'(m_cnt_b));
`ifdef NUM_COLL_SOUND_EN
    chk("hitSound_a", 32'(bus_a.hitSound), 32'(m_snd != 0));
`endif
  endtask

  // Apply inputs for one cycle, advance the model at the edge, check after it.
  task automatic cyc(input logic s, input logic l, input logic p, input logic [2:0] n);
    sof = s;
    lr  = l;
    pdr = p;
    ndr = n;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int len;
    reset = 1'b1;
    sof = 1'b0; lr = 1'b0; pdr = 1'b0; ndr = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_singleHit", 32'(bus_a.singleHit), 32'h0);
    chk("reset_hitCount", 32'(bus_a.hitCount), 32'h0);
    reset = 1'b0;

    // Reset in the middle of a frame discards the pending overlap.
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, 1'b1, 3'b010);
    reset = 1'b1;
    #2;
    model_reset();
    chk("midreset_hitMask", 32'(bus_a.hitMask), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t1_no_pulse", 32'(bus_a.singleHit), 32'h0);

    // Five overlap pixels on number 0 give one pulse at the next frame only.
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 3'b001);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t2_pulse", 32'(bus_a.singleHit), 32'h1);
    chk("t2_count", 32'(bus_a.hitCount), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 3'b001);
    chk("t2_pulse_one_cycle", 32'(bus_a.singleHit), 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 3'b001);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t2_no_repulse", 32'(bus_a.singleHit), 32'h0);

    // Restart, then hit numbers 0 and 2 in the same frame.
    cyc(1'b0, 1'b1, 1'b0, 3'b000);
    chk("t3_restart_mask", 32'(bus_a.hitMask), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, 1'b1, 3'b001);
    cyc(1'b0, 1'b0, 1'b1, 3'b100);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t3_pulse", 32'(bus_a.singleHit), 32'h5);
    chk("t3_count", 32'(bus_a.hitCount), 32'h2);
    chk("t3_count_sat", 32'(bus_b.hitCount), 32'h1);

    // Overlap on the start-of-frame pixel belongs to the new frame.
    cyc(1'b1, 1'b0, 1'b1, 3'b010);
    chk("t4_not_now", 32'(bus_a.singleHit), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t4_pulse", 32'(bus_a.singleHit), 32'h2);
    chk("t4_mask_full", 32'(bus_a.hitMask), 32'h7);
    chk("t4_allcleared_late", 32'(bus_a.allCleared), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    chk("t5_allcleared", 32'(bus_a.allCleared), 32'h1);
    chk("t6_sat_mask", 32'(bus_b.hitMask), 32'h7);
    chk("t6_sat_count", 32'(bus_b.hitCount), 32'h1);

    // levelRestart beats a simultaneous startOfFrame.
    cyc(1'b0, 1'b1, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, 1'b1, 3'b011);
    cyc(1'b1, 1'b1, 1'b0, 3'b000);
    chk("t5_lr_no_pulse", 32'(bus_a.singleHit), 32'h0);
    chk("t5_lr_count", 32'(bus_a.hitCount), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t5_pending_cleared", 32'(bus_a.singleHit), 32'h0);

    // Without startOfFrame the pending hit simply waits.
    cyc(1'b0, 1'b0, 1'b1, 3'b100);
    repeat (30) cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("hold_pulse", 32'(bus_a.singleHit), 32'h4);

    // Random frames with occasional restarts.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(6, 20);
      cyc(1'b1, ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      for (int k = 1; k < len; k++) begin
        cyc(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
